// File: rtl/button_cmd_scheduler_pkg.sv
// Shared types and helpers for the button command scheduler.
// Holds the arbiter state encoding and the ID width derivation.
package button_cmd_scheduler_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int v = n - 1; v > 0; v = v >> 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/button_hold_qualifier.sv
// One button: 2-FF synchroniser, release-arming, hold counter and a
// single-cycle event when the hold reaches HOLD_CYCLES.
module button_hold_qualifier #(
  parameter int HOLD_CYCLES = 500000,
  parameter int CNT_W       = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic ev
);

  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [1:0]       sync;
  logic             s;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  assign s = sync[1];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchroniser resets to "pressed" so a button held through reset
      // cannot look like a release and arm itself.
      sync  <= 2'b11;
      armed <= 1'b0;
      cnt   <= '0;
      ev    <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (!s) armed <= 1'b1;
      if (!s)
        cnt <= '0;
      else if (armed && cnt < HOLD_MAX)
        cnt <= cnt + 1'b1;
      ev <= s && armed && (cnt == HOLD_LAST);
    end
  end

endmodule

// File: rtl/button_cmd_scheduler.sv
// Qualifies N_BTN buttons and serialises their press events onto one
// valid/ready command port with round-robin arbitration.
module button_cmd_scheduler
  import button_cmd_scheduler_pkg::*;
#(
  parameter  int N_BTN       = 4,
  parameter  int HOLD_CYCLES = 500000,
  parameter  int CNT_W       = 20,
  localparam int ID_W        = clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [ID_W-1:0]  cmd_id,
  output logic [N_BTN-1:0] pending,
  output logic             overrun,
  output logic [ID_W-1:0]  overrun_id
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_BTN - 1);

  logic [N_BTN-1:0] ev;
  logic [N_BTN-1:0] grant;
  logic [N_BTN-1:0] ovr;
  logic [ID_W-1:0]  ovr_id;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  pick_id;
  logic [ID_W-1:0]  scan;
  logic             pick_found;
  logic             hs;
  logic             load_id;
  logic             adv_ptr;
  arb_state_e       state, state_nxt;

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    button_hold_qualifier #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .CNT_W      (CNT_W)
    ) u_qual (
      .clk(clk),
      .rst(rst),
      .btn(btn_in[gi]),
      .ev (ev[gi])
    );
  end

  assign cmd_valid = (state == ST_OFFER);
  assign hs        = cmd_valid && cmd_ready;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    grant = '0;
    if (hs) grant[cmd_id] = 1'b1;
    ovr = ev & pending & ~grant;
  end

  // Round-robin: first pending bit at or after ptr, wrapping at N_BTN-1.
  always_comb begin
    pick_id    = '0;
    pick_found = 1'b0;
    scan       = ptr;
    for (int k = 0; k < N_BTN; k++) begin
      if (!pick_found && pending[scan]) begin
        pick_id    = scan;
        pick_found = 1'b1;
      end
      scan = (scan == LAST_ID) ? '0 : scan + 1'b1;
    end
  end

  always_comb begin
    ovr_id = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (ovr[i]) ovr_id = ID_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    load_id   = 1'b0;
    adv_ptr   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt = ST_OFFER;
          load_id   = 1'b1;
        end
      end
      ST_OFFER: begin
        if (cmd_ready) begin
          state_nxt = ST_IDLE;
          adv_ptr   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_id     <= '0;
      ptr        <= '0;
      pending    <= '0;
      overrun    <= 1'b0;
      overrun_id <= '0;
    end else begin
      if (load_id) cmd_id <= pick_id;
      if (adv_ptr) ptr <= (cmd_id == LAST_ID) ? '0 : cmd_id + 1'b1;
      // A fresh event on the granted button re-queues it instead of overrunning.
      pending    <= ev | (pending & ~grant);
      overrun    <= |ovr;
      overrun_id <= ovr_id;
    end
  end

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Directed bench for button_cmd_scheduler with an event-level reference model
// compared every cycle, plus literal expectations for each scenario.
module tb_button_cmd_scheduler;

  localparam int N  = 4;
  localparam int H  = 8;
  localparam int CW = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  btn_in = '0;
  logic          cmd_ready = 1'b0;
  logic          cmd_valid;
  logic [IW-1:0] cmd_id;
  logic [N-1:0]  pending;
  logic          overrun;
  logic [IW-1:0] overrun_id;

  button_cmd_scheduler #(.N_BTN(N), .HOLD_CYCLES(H), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_id    (cmd_id),
    .pending   (pending),
    .overrun   (overrun),
    .overrun_id(overrun_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: press events from raw samples, then a pending set and a
  // single offered command chosen round-robin.
  bit           live = 1'b0;
  int           cyc = 0;
  bit           armed_m[N];
  int           run_m[N];
  logic [N-1:0] d0, d1, d2;
  logic [N-1:0] m_pend;
  bit           m_offering;
  int           m_id, m_ptr;
  bit           m_ovr;
  int           m_ovr_id;

  int hs_id[$];
  int hs_cyc[$];
  int ov_cnt;
  int ov_last;

  always @(posedge clk) begin
    logic [N-1:0] ev_now, ev_new, gmask, old_pend;
    bit found;
    int idx;
    cyc++;
    if (!rst && cmd_valid && cmd_ready) begin
      hs_id.push_back(int'(cmd_id));
      hs_cyc.push_back(cyc);
    end
    if (rst) begin
      live = 1'b1;
      for (int i = 0; i < N; i++) begin
        armed_m[i] = 1'b0;
        run_m[i]   = 0;
      end
      d0 = '0; d1 = '0; d2 = '0;
      m_pend = '0; m_offering = 1'b0; m_id = 0; m_ptr = 0;
      m_ovr = 1'b0; m_ovr_id = 0;
    end else begin
      ev_now = d2;
      gmask  = '0;
      if (m_offering && cmd_ready) gmask[m_id] = 1'b1;
      m_ovr = 1'b0;
      m_ovr_id = 0;
      for (int i = N - 1; i >= 0; i--)
        if (ev_now[i] && m_pend[i] && !gmask[i]) begin
          m_ovr = 1'b1;
          m_ovr_id = i;
        end
      old_pend = m_pend;
      if (m_offering) begin
        if (cmd_ready) begin
          m_offering = 1'b0;
          m_ptr = (m_id + 1) % N;
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!found && old_pend[idx]) begin
            found = 1'b1;
            m_id = idx;
          end
        end
        m_offering = found;
      end
      m_pend = ev_now | (old_pend & ~gmask);
      ev_new = '0;
      for (int i = 0; i < N; i++) begin
        if (!btn_in[i]) begin
          armed_m[i] = 1'b1;
          run_m[i] = 0;
        end else if (armed_m[i] && run_m[i] < H) begin
          run_m[i]++;
          if (run_m[i] == H) ev_new[i] = 1'b1;
        end
      end
      d2 = d1; d1 = d0; d0 = ev_new;
    end
  end

  always @(negedge clk) begin
    if (live) begin
      check("cmd_valid", cmd_valid, m_offering);
      if (m_offering) check("cmd_id", cmd_id, m_id);
      check("pending", pending, m_pend);
      check("overrun", overrun, m_ovr);
      if (m_ovr) check("overrun_id", overrun_id, m_ovr_id);
      if (overrun) begin
        ov_cnt++;
        ov_last = int'(overrun_id);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic clear_log();
    hs_id.delete();
    hs_cyc.delete();
    ov_cnt = 0;
  endtask

  function automatic int hs_at(input int i);
    return (i < hs_id.size()) ? hs_id[i] : -1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    tick(3);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_id", cmd_id, 0);
    check("rst_pending", pending, 0);
    check("rst_overrun", overrun, 0);
    check("rst_overrun_id", overrun_id, 0);
    rst = 1'b0;
    tick(3);

    // 1: long hold on button 2 gives one command, 12 clocks after the rise.
    clear_log();
    cmd_ready = 1'b1;
    btn_in[2] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      tick(1);
      if (cmd_valid) lat = k;
    end
    check("t1_latency", lat, 12);
    tick(20 - lat);
    btn_in[2] = 1'b0;
    tick(20);
    check("t1_cmd_count", hs_id.size(), 1);
    check("t1_cmd_id", hs_at(0), 2);

    // 2: two short holds separated by a 1-clock release never qualify.
    clear_log();
    btn_in[1] = 1'b1; tick(5);
    btn_in[1] = 1'b0; tick(1);
    btn_in[1] = 1'b1; tick(5);
    btn_in[1] = 1'b0; tick(20);
    check("t2_cmd_count", hs_id.size(), 0);
    check("t2_pending", pending, 0);

    // 3: three simultaneous events are granted 0,1,3 two clocks apart.
    do_reset();
    tick(3);
    clear_log();
    cmd_ready = 1'b1;
    btn_in = 4'b1011;
    tick(12);
    btn_in = '0;
    tick(20);
    check("t3_cmd_count", hs_id.size(), 3);
    check("t3_id0", hs_at(0), 0);
    check("t3_id1", hs_at(1), 1);
    check("t3_id2", hs_at(2), 3);
    check("t3_gap01", (hs_cyc.size() == 3) ? hs_cyc[1] - hs_cyc[0] : -1, 2);
    check("t3_gap12", (hs_cyc.size() == 3) ? hs_cyc[2] - hs_cyc[1] : -1, 2);
    check("t3_model_ptr", m_ptr, 0);

    // 4: second event on a still-pending button overruns exactly once.
    do_reset();
    tick(3);
    clear_log();
    cmd_ready = 1'b0;
    btn_in[1] = 1'b1; tick(10);
    btn_in[1] = 1'b0; tick(3);
    btn_in[1] = 1'b1; tick(10);
    btn_in[1] = 1'b0; tick(5);
    check("t4_overrun_pulses", ov_cnt, 1);
    check("t4_overrun_id", ov_last, 1);
    check("t4_pending1", pending[1], 1);
    cmd_ready = 1'b1;
    tick(10);
    check("t4_cmd_count", hs_id.size(), 1);
    check("t4_cmd_id", hs_at(0), 1);

    // 5: button held through reset waits for a release before qualifying.
    btn_in[3] = 1'b1;
    tick(2);
    rst = 1'b1; tick(3);
    rst = 1'b0;
    clear_log();
    cmd_ready = 1'b1;
    tick(20);
    check("t5_held_cmd_count", hs_id.size(), 0);
    check("t5_held_pending", pending, 0);
    btn_in[3] = 1'b0; tick(2);
    btn_in[3] = 1'b1; tick(12);
    btn_in[3] = 1'b0; tick(5);
    check("t5_rehold_count", hs_id.size(), 1);
    check("t5_rehold_id", hs_at(0), 3);

    // 5b: reset while a command is offered drops it for good.
    clear_log();
    cmd_ready = 1'b0;
    btn_in[0] = 1'b1;
    seen = 0;
    for (int k = 0; k < 30 && seen == 0; k++) begin
      tick(1);
      if (cmd_valid) seen = 1;
    end
    check("t5_offer_seen", seen, 1);
    rst = 1'b1;
    btn_in[0] = 1'b0;
    tick(1);
    check("t5_rst_valid", cmd_valid, 0);
    check("t5_rst_pending", pending, 0);
    tick(1);
    rst = 1'b0;
    cmd_ready = 1'b1;
    tick(20);
    check("t5_no_replay", hs_id.size(), 0);

    // 6: event on button 2 in its own grant cycle re-queues it.
    do_reset();
    tick(3);
    clear_log();
    cmd_ready = 1'b0;
    btn_in[2] = 1'b1; tick(10);
    btn_in[2] = 1'b0; tick(6);
    btn_in[2] = 1'b1; tick(10);
    cmd_ready = 1'b1;
    tick(1);
    check("t6_pending2_kept", pending[2], 1);
    check("t6_idle_gap", cmd_valid, 0);
    tick(1);
    btn_in[2] = 1'b0;
    tick(10);
    check("t6_cmd_count", hs_id.size(), 2);
    check("t6_id0", hs_at(0), 2);
    check("t6_id1", hs_at(1), 2);
    check("t6_overruns", ov_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
